p2s_tx: RTL and testbench

Parallel-to-serial transmitter for the host/slave serial link. It accepts a DATA_WIDTH-bit word through a ready/send handshake and shifts it out MSB first, one bit per `clk1x` cycle. It emits a one-cycle frame-sync marker on the first bit, which can drive the far-end receiver's `receiveFlag`, and a one-cycle `done` pulse when the word completes. Back-to-back words stream with no idle gap.

---
 rtl/p2s_tx.sv | 68 ++++++
 tb/tb_p2s_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: MSB-first shift-out of DATA_WIDTH-bit words with
// a frame-sync marker on the first bit and a done pulse after the last bit.
module p2s_tx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk1x,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  sendFlag,
    output logic                  ready,
    output logic                  dataSOUT,
    output logic                  frameSync,
    output logic                  done
);

    // state | meaning
    // IDLE  | line idle at 0, ready for a word
    // SHIFT | word on the line, one bit per clk1x cycle
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int              CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CW-1:0]           cnt;
    logic                    last_bit;
    logic                    accept;

    // ready depends on state and counter only, so accept never loops back through sendFlag
    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign ready    = (state == IDLE) || last_bit;
    assign accept   = sendFlag && ready;

    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            dataSOUT  <= 1'b0;
            frameSync <= 1'b0;
            done      <= 1'b0;
        end else begin
            frameSync <= accept;
            done      <= last_bit;
            if (accept) begin
                state    <= SHIFT;
                shreg    <= dataIn;
                cnt      <= '0;
                dataSOUT <= dataIn[DATA_WIDTH-1];
            end else if (last_bit) begin
                state    <= IDLE;
                shreg    <= '0;
                cnt      <= '0;
                dataSOUT <= 1'b0;
            end else if (state == SHIFT) begin
                // dataSOUT tracks the MSB of the shifted register
                shreg    <= shreg << 1;
                cnt      <= cnt + 1'b1;
                dataSOUT <= shreg[DATA_WIDTH-2];
            end
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// Scoreboard bench for p2s_tx: stimulus pushes accepted words, a negedge monitor
// aligns on frameSync and checks every serial bit, ready and done.
module tb_p2s_tx;

    logic        clk1x = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] dataIn = 16'h0000;
    logic        sendFlag = 1'b0;
    logic        ready, dataSOUT, frameSync, done;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    p2s_tx #(.DATA_WIDTH(16)) dut (
        .clk1x    (clk1x),
        .reset    (reset),
        .dataIn   (dataIn),
        .sendFlag (sendFlag),
        .ready    (ready),
        .dataSOUT (dataSOUT),
        .frameSync(frameSync),
        .done     (done)
    );

    always #5 clk1x = ~clk1x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Called at a negedge: present the word, wait for its acceptance edge, log it.
    task automatic send_word(input logic [15:0] data, input bit keep);
        dataIn   = data;
        sendFlag = 1'b1;
        @(posedge clk1x);
        exp_q.push_back(data);
        @(negedge clk1x);
        if (!keep) sendFlag = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dataSOUT"},  {31'd0, dataSOUT},  32'd0);
        chk({tag, "_frameSync"}, {31'd0, frameSync}, 32'd0);
        chk({tag, "_done"},      {31'd0, done},      32'd0);
        chk({tag, "_ready"},     {31'd0, ready},     32'd1);
    endtask

    // Monitor
    initial begin : monitor
        logic [15:0] cur;
        int          idx;
        bit          active;
        bit          pend_done;
        cur = '0; idx = 0; active = 0; pend_done = 0;
        forever begin
            @(negedge clk1x);
            if (!reset) begin
                active    = 0;
                pend_done = 0;
            end else begin
                chk("done", {31'd0, done}, {31'd0, pend_done});
                pend_done = 0;
                if (frameSync) begin
                    chk("frame_while_busy", {31'd0, active}, 32'd0);
                    chk("frame_expected", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
                    if (exp_q.size() != 0) begin
                        cur    = exp_q.pop_front();
                        active = 1;
                        idx    = 0;
                    end
                end
                if (active) begin
                    chk("bit", {31'd0, dataSOUT}, {31'd0, cur[15-idx]});
                    chk("ready_busy", {31'd0, ready}, (idx == 15) ? 32'd1 : 32'd0);
                    idx++;
                    if (idx == 16) begin
                        active    = 0;
                        pend_done = 1;
                    end
                end else begin
                    chk("idle_dataSOUT", {31'd0, dataSOUT}, 32'd0);
                    chk("idle_ready",    {31'd0, ready},    32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Power-on reset
        repeat (3) @(negedge clk1x);
        #1 check_reset_outputs("por");
        @(negedge clk1x);
        reset = 1'b1;
        repeat (3) @(negedge clk1x);

        // Single word
        send_word(16'hA5C3, 0);
        repeat (22) @(negedge clk1x);

        // Back-to-back: FFFF held, 0001 presented at E16
        send_word(16'hFFFF, 1);
        repeat (15) @(negedge clk1x);
        send_word(16'h0001, 0);
        repeat (20) @(negedge clk1x);

        // Request while busy is ignored
        send_word(16'h8001, 0);
        repeat (4) @(negedge clk1x);
        dataIn   = 16'h1234;
        sendFlag = 1'b1;
        @(negedge clk1x);
        sendFlag = 1'b0;
        repeat (20) @(negedge clk1x);

        // Reset mid-word
        send_word(16'hFFFF, 0);
        repeat (7) @(negedge clk1x);
        reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        repeat (3) @(negedge clk1x);
        check_reset_outputs("held_rst");
        reset = 1'b1;
        repeat (3) @(negedge clk1x);
        send_word(16'h00FF, 0);
        repeat (20) @(negedge clk1x);

        // dataIn changes after acceptance have no effect
        send_word(16'h0F0F, 0);
        dataIn = 16'hF0F0;
        repeat (20) @(negedge clk1x);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
